// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: shared types and helpers for the mem_bank slice.
// Holds the controller state encoding and the byte-lane parity function.
package mem_bank_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Even parity bit for one byte lane: the byte plus this bit hold an even number of ones
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mem_bank_array.sv
// mem_bank_array: word storage with per-lane synchronous write and registered read.
// Contents are never reset; the owner is responsible for initialising them.
module mem_bank_array #(
    parameter  int DEPTH = 256,
    parameter  int NB    = 2,
    parameter  int LW    = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int WW    = NB * LW
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [NB-1:0] i_lane_en,
    input  logic [AW-1:0] i_waddr,
    input  logic [WW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [WW-1:0] o_rdata
);

    logic [WW-1:0] mem [DEPTH];

    // Lane-masked write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned n = 0; n < NB; n++) begin
                if (i_lane_en[n]) begin
                    mem[i_waddr][n*LW +: LW] <= i_wdata[n*LW +: LW];
                end
            end
        end
    end

    // Registered read port; output holds between reads
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/mem_bank.sv
// mem_bank: single-port byte-lane memory with a power-up clear sweep.
// After reset the controller zeroes every word (o_busy high), then accepts
// one read or write per cycle. Reads return one cycle later with o_rvalid.
// Optional feature: define MEM_BANK_PARITY_EN to store one even-parity bit
// per byte lane and add the o_perr / i_perr_inj ports.
module mem_bank
    import mem_bank_pkg::*;
#(
    parameter  int BITS     = 16,
    parameter  int MEMADDRS = 256,
    localparam int AW       = $clog2(MEMADDRS),
    localparam int NB       = BITS / 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req,
    input  logic            i_rw,
    input  logic [AW-1:0]   i_addr,
    input  logic [BITS-1:0] i_data,
    input  logic [NB-1:0]   i_be,
    output logic            o_ready,
    output logic            o_rvalid,
    output logic [BITS-1:0] o_data,
    output logic            o_busy
`ifdef MEM_BANK_PARITY_EN
    ,
    output logic            o_perr,
    input  logic            i_perr_inj
`endif
);

`ifdef MEM_BANK_PARITY_EN
    localparam int LW = 9;
`else
    localparam int LW = 8;
`endif
    localparam int            WW        = NB * LW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEMADDRS - 1);

    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic          rvalid_q;
    logic          zero_q;
    logic          busy_q;
    logic          ready_q;

    logic          accept;
    logic          in_range;
    logic          rd_acc;
    logic          wr_acc;

    logic          arr_we;
    logic [NB-1:0] arr_lane_en;
    logic [AW-1:0] arr_waddr;
    logic [WW-1:0] arr_wdata;
    logic          arr_re;
    logic [WW-1:0] arr_rdata;

    // A full power-of-two depth makes every address legal
    generate
        if (MEMADDRS == (2 ** AW)) begin : g_full_depth
            assign in_range = 1'b1;
        end else begin : g_partial_depth
            assign in_range = (i_addr <= LAST_ADDR);
        end
    endgenerate

    assign accept = i_req & ready_q;
    assign rd_acc = accept & ~i_rw;
    assign wr_acc = accept & i_rw & in_range;

    // Write-port mux: the clear sweep owns the port in S_INIT, requests in S_RUN
    always_comb begin
        arr_we      = 1'b0;
        arr_lane_en = '0;
        arr_waddr   = clr_ptr;
        arr_wdata   = '0;
        if (state == S_INIT && i_rst_n) begin
            arr_we      = 1'b1;
            arr_lane_en = '1;
        end else if (wr_acc) begin
            arr_we      = 1'b1;
            arr_lane_en = i_be;
            arr_waddr   = i_addr;
            for (int unsigned n = 0; n < NB; n++) begin
                arr_wdata[n*LW +: 8] = i_data[n*8 +: 8];
`ifdef MEM_BANK_PARITY_EN
                arr_wdata[n*LW + 8] = byte_parity(i_data[n*8 +: 8]) ^ i_perr_inj;
`endif
            end
        end
    end

    // Out-of-range reads skip the array; zero_q masks the stale array output
    assign arr_re = rd_acc & in_range & i_rst_n;

    mem_bank_array #(
        .DEPTH (MEMADDRS),
        .NB    (NB),
        .LW    (LW)
    ) u_array (
        .i_clk     (i_clk),
        .i_we      (arr_we),
        .i_lane_en (arr_lane_en),
        .i_waddr   (arr_waddr),
        .i_wdata   (arr_wdata),
        .i_re      (arr_re),
        .i_raddr   (i_addr),
        .o_rdata   (arr_rdata)
    );

    // Controller FSM: clear sweep, then service; tracks read-valid and zero-mask flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_INIT;
            clr_ptr  <= '0;
            rvalid_q <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                zero_q <= ~in_range;
            end
            case (state)
                S_INIT: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= S_RUN;
                        clr_ptr <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Strip parity bits from the read word and apply the zero mask
    always_comb begin
        o_data = '0;
        for (int unsigned n = 0; n < NB; n++) begin
            o_data[n*8 +: 8] = zero_q ? 8'h00 : arr_rdata[n*LW +: 8];
        end
    end

`ifdef MEM_BANK_PARITY_EN
    logic [NB-1:0] lane_mismatch;

    // Compare each stored parity bit against the parity of its returned byte
    always_comb begin
        lane_mismatch = '0;
        for (int unsigned n = 0; n < NB; n++) begin
            lane_mismatch[n] = byte_parity(arr_rdata[n*LW +: 8]) ^ arr_rdata[n*LW + 8];
        end
    end

    assign o_perr = rvalid_q & ~zero_q & (|lane_mismatch);
`endif

    assign o_rvalid = rvalid_q;
    assign o_busy   = busy_q;
    assign o_ready  = ready_q;

endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: directed vector bench for mem_bank (full depth and 200-word depth).
module tb_mem_bank;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        rw;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
`ifdef MEM_BANK_PARITY_EN
    logic        perr_inj;
    logic        a_perr;
    logic        b_perr;
`endif

    logic        a_ready, a_rvalid, a_busy;
    logic [15:0] a_data;
    logic        b_ready, b_rvalid, b_busy;
    logic [15:0] b_data;

    int checks = 0;
    int errors = 0;

    mem_bank #(.BITS(16), .MEMADDRS(256)) dut_a (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_rw     (rw),
        .i_addr   (addr),
        .i_data   (data),
        .i_be     (be),
        .o_ready  (a_ready),
        .o_rvalid (a_rvalid),
        .o_data   (a_data),
        .o_busy   (a_busy)
`ifdef MEM_BANK_PARITY_EN
        ,
        .o_perr     (a_perr),
        .i_perr_inj (perr_inj)
`endif
    );

    mem_bank #(.BITS(16), .MEMADDRS(200)) dut_b (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_rw     (rw),
        .i_addr   (addr),
        .i_data   (data),
        .i_be     (be),
        .o_ready  (b_ready),
        .o_rvalid (b_rvalid),
        .o_data   (b_data),
        .o_busy   (b_busy)
`ifdef MEM_BANK_PARITY_EN
        ,
        .o_perr     (b_perr),
        .i_perr_inj (perr_inj)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic        exp_rv;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] a,
                         input logic [15:0] d, input logic [1:0] e);
        req  = r;
        rw   = w;
        addr = a;
        data = d;
        be   = e;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        int n, na, nb;
        logic saw_rv;

        // {req, rw, addr, data, be, exp_rvalid, exp_data}
        vecs[0]  = '{1'b1, 1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 8'd128, 16'h0000, 2'b00, 1'b1, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 8'd255, 16'h0000, 2'b00, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 8'd3,   16'hABCD, 2'b11, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 1'b1, 8'd3,   16'h12FF, 2'b01, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 8'd3,   16'h0000, 2'b00, 1'b1, 16'hABFF};
        vecs[6]  = '{1'b0, 1'b0, 8'd3,   16'h0000, 2'b00, 1'b0, 16'hABFF};
        vecs[7]  = '{1'b1, 1'b1, 8'd7,   16'h195A, 2'b11, 1'b0, 16'hABFF};
        vecs[8]  = '{1'b1, 1'b0, 8'd7,   16'h0000, 2'b00, 1'b1, 16'h195A};
        vecs[9]  = '{1'b1, 1'b1, 8'd7,   16'hFFFF, 2'b00, 1'b0, 16'h195A};
        vecs[10] = '{1'b1, 1'b0, 8'd7,   16'h0000, 2'b00, 1'b1, 16'h195A};
        vecs[11] = '{1'b1, 1'b1, 8'd9,   16'h1234, 2'b10, 1'b0, 16'h195A};
        vecs[12] = '{1'b1, 1'b0, 8'd9,   16'h0000, 2'b00, 1'b1, 16'h1200};
        vecs[13] = '{1'b1, 1'b0, 8'd3,   16'h0000, 2'b00, 1'b1, 16'hABFF};
        vecs[14] = '{1'b0, 1'b1, 8'd3,   16'h5555, 2'b11, 1'b0, 16'hABFF};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
`ifdef MEM_BANK_PARITY_EN
        perr_inj = 1'b0;
`endif
        tick();
        tick();
        chk("rst busy", a_busy, 1'b1);
        chk("rst ready", a_ready, 1'b0);
        chk("rst rvalid", a_rvalid, 1'b0);
        chk("rst data", a_data, 16'h0000);

        // Initial clear sweep length for both depths
        rst_n = 1'b1;
        n = 0; na = 0; nb = 0;
        while ((a_busy || b_busy) && n < 1000) begin
            tick();
            n++;
            if (!a_busy && na == 0) na = n;
            if (!b_busy && nb == 0) nb = n;
        end
        chk("init cycles 256", na, 256);
        chk("init cycles 200", nb, 200);
        chk("ready after init", a_ready, 1'b1);

        // Main table
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].req, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].be);
            tick();
            chk($sformatf("vec%0d rvalid", i), a_rvalid, vecs[i].exp_rv);
            chk($sformatf("vec%0d data", i), a_data, vecs[i].exp_data);
        end

        // Depth edge on the 200-word instance
        drive(1'b1, 1'b1, 8'd199, 16'hBEEF, 2'b11);
        tick();
        drive(1'b1, 1'b0, 8'd199, 16'h0000, 2'b00);
        tick();
        chk("d200 rd199 rvalid", b_rvalid, 1'b1);
        chk("d200 rd199 data", b_data, 16'hBEEF);
        drive(1'b1, 1'b1, 8'd210, 16'hFFFF, 2'b11);
        tick();
        chk("d200 wr210 rvalid", b_rvalid, 1'b0);
        drive(1'b1, 1'b0, 8'd210, 16'h0000, 2'b00);
        tick();
        chk("d200 rd210 rvalid", b_rvalid, 1'b1);
        chk("d200 rd210 data", b_data, 16'h0000);
        chk("d256 rd210 data", a_data, 16'hFFFF);
        drive(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
        tick();
        chk("rvalid single pulse", a_rvalid, 1'b0);

`ifdef MEM_BANK_PARITY_EN
        drive(1'b1, 1'b1, 8'd20, 16'h00FF, 2'b01);
        perr_inj = 1'b1;
        tick();
        perr_inj = 1'b0;
        drive(1'b1, 1'b0, 8'd20, 16'h0000, 2'b00);
        tick();
        chk("par inj data", a_data, 16'h00FF);
        chk("par inj perr", a_perr, 1'b1);
        drive(1'b1, 1'b1, 8'd20, 16'h00FF, 2'b01);
        tick();
        chk("par wr perr idle", a_perr, 1'b0);
        drive(1'b1, 1'b0, 8'd20, 16'h0000, 2'b00);
        tick();
        chk("par clean rvalid", a_rvalid, 1'b1);
        chk("par clean perr", a_perr, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
        tick();
`endif

        // Reset coinciding with a read request discards the read
        drive(1'b1, 1'b0, 8'd3, 16'h0000, 2'b00);
        rst_n = 1'b0;
        tick();
        chk("rst-read rvalid", a_rvalid, 1'b0);
        chk("rst-read data", a_data, 16'h0000);
        chk("rst-read busy", a_busy, 1'b1);
        chk("rst-read ready", a_ready, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
        rst_n = 1'b1;

        // Reset pulse at cycle 100 of the clear restarts the sweep
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        saw_rv = 1'b0;
        while (a_busy && n < 1000) begin
            if (n == 50) drive(1'b1, 1'b0, 8'd3, 16'h0000, 2'b00);
            tick();
            n++;
            if (a_rvalid) saw_rv = 1'b1;
            drive(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
        end
        chk("midinit busy cycles", n, 256);
        chk("midinit no rvalid", saw_rv, 1'b0);
        chk("midinit ready", a_ready, 1'b1);

        // Previously written word is cleared again
        drive(1'b1, 1'b0, 8'd3, 16'h0000, 2'b00);
        tick();
        chk("recleared rvalid", a_rvalid, 1'b1);
        chk("recleared data", a_data, 16'h0000);
        drive(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 The block SHALL have parameter BITS, default 16, meaning data word width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter MEMADDRS, default 256, meaning number of words; any value 2..65536 is legal.
REQ-003 The block SHALL have localparam AW = $clog2(MEMADDRS), meaning address width, and localparam NB = BITS/8, meaning byte lanes.
REQ-004 The block SHALL have port i_clk, input, 1 bit: sole clock; all logic on rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port i_req, input, 1 bit: access request.
REQ-007 The block SHALL have port i_rw, input, 1 bit: LOW read, HIGH write.
REQ-008 The block SHALL have port i_addr, input, AW bits: word address.
REQ-009 The block SHALL have port i_data, input, BITS bits: write data.
REQ-010 The block SHALL have port i_be, input, NB bits: write byte enables; bit n covers i_data[8n+7:8n].
REQ-011 The block SHALL have port o_ready, output, 1 bit: block accepts requests.
REQ-012 The block SHALL have port o_rvalid, output, 1 bit: o_data holds a fresh read result.
REQ-013 The block SHALL have port o_data, output, BITS bits: registered read data.
REQ-014 The block SHALL have port o_busy, output, 1 bit: init clear in progress.

Function
REQ-015 The block SHALL use a two-state FSM: S_INIT, then S_RUN.
REQ-016 S_INIT SHALL write zero to one address per cycle, ascending from 0, and transition to S_RUN after address MEMADDRS-1 is cleared (exactly MEMADDRS cycles).
REQ-017 o_busy SHALL be 1 and o_ready SHALL be 0 in S_INIT; in S_RUN o_busy SHALL be 0 and o_ready SHALL be 1.
REQ-018 An access SHALL be accepted only when i_req && o_ready at a rising edge; i_req in S_INIT SHALL be ignored and not queued.
REQ-019 An accepted write SHALL update only the byte lanes with i_be set; i_be==0 SHALL be accepted with no change.
REQ-020 An accepted read SHALL have 1-cycle latency: o_rvalid=1 and o_data=word on the following cycle.
REQ-021 o_rvalid SHALL be a single-cycle pulse per read; o_data SHALL hold its last value until the next accepted read.
REQ-022 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-023 Addresses >= MEMADDRS (non-power-of-2 depth) SHALL be ignored on write and SHALL return all-zero on read, with o_rvalid still pulsed.
REQ-024 Writes SHALL never produce o_rvalid.

Reset
REQ-025 When i_rst_n=0 at a rising edge, the FSM SHALL go to S_INIT with clear pointer 0, o_rvalid=0, o_data=0, o_ready=0, and o_busy=1 from the next cycle.
REQ-026 Reset asserted mid-S_INIT or mid-read SHALL restart the clear from address 0 and discard the pending read.
REQ-027 Array contents SHALL NOT be reset directly; only the S_INIT sweep clears them.

Configuration
REQ-028 Macro MEM_BANK_PARITY_EN SHALL, when defined, store one even-parity bit per byte lane.
REQ-029 With MEM_BANK_PARITY_EN defined, the block SHALL add output o_perr (1 bit), asserted with o_rvalid when any read lane's parity mismatches, else 0.
REQ-030 With MEM_BANK_PARITY_EN defined, the block SHALL add input i_perr_inj (1 bit), which inverts the stored parity of enabled lanes on that write.
REQ-031 Without MEM_BANK_PARITY_EN, the block SHALL have no parity storage and no o_perr or i_perr_inj ports.
REQ-032 The S_INIT sweep SHALL write correct parity (0) for cleared words.

Structure
REQ-033 Package mem_bank_pkg SHALL hold the FSM state enum (S_INIT, S_RUN) and the byte-lane parity function.
REQ-034 Storage SHALL be a sub-module mem_bank_array: synchronous write with per-lane enable and registered read, no reset.
REQ-035 The FSM, clear pointer, address-range check and parity logic SHALL live in mem_bank.

Verification
REQ-036 Bench SHALL cover reset release: o_busy=1 for exactly 256 cycles, then o_ready=1, and reads of addresses 0, 128 and 255 return 0x0000.
REQ-037 Bench SHALL cover a byte-enable write: write 0xABCD with i_be=2'b11 to address 3, then 0x12FF with i_be=2'b01; the read returns 0xABFF with o_rvalid one cycle after the request.
REQ-038 Bench SHALL cover back-to-back access: write 0x195A to address 7, then read address 7 on the next cycle; o_data=0x195A one cycle later.
REQ-039 Bench SHALL cover reset mid-init: pulse i_rst_n low at cycle 100 of the clear; o_busy stays 1 for 256 further cycles, and a read issued during init yields no o_rvalid.
REQ-040 Bench SHALL cover depth edge: with MEMADDRS=200, write 0xFFFF to address 210 and read it back; the result is 0x0000 with o_rvalid=1, and address 199 is writable.
REQ-041 Bench SHALL cover parity, with MEM_BANK_PARITY_EN defined: write 0x00FF with i_perr_inj=1, i_be=2'b01; the read gives o_perr=1, and a rewrite without injection gives o_perr=0.
